// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line sequencer.
// The serial CRC7 step is kept here so the engine and its CRC sub-module use the same polynomial.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_TRAIL
  } sd_state_e;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_ARG  = 2'd1;
  localparam logic [1:0] ADDR_RESP = 2'd2;
  localparam logic [1:0] ADDR_DIV  = 2'd3;

  localparam logic [1:0] RTYPE_NONE      = 2'b00;
  localparam logic [1:0] RTYPE_R48       = 2'b01;
  localparam logic [1:0] RTYPE_R48_NOCRC = 2'b10;

  localparam int CTRL_BIT_START = 8;
  localparam int CTRL_BIT_INIT  = 9;

  localparam int STAT_BIT_BUSY    = 11;
  localparam int STAT_BIT_TIMEOUT = 10;
  localparam int STAT_BIT_CRC     = 9;
  localparam int STAT_BIT_END     = 8;

  // x^7 + x^3 + 1, MSB-first serial update
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: clear restarts from zero, and a bit may be folded in the same cycle.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) crc_d = '0;
    if (enable_i) crc_d = crc7_step(crc_d, bit_i);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command-line sequencer: bus register file, SD_CLK divider, 48-bit command shift-out,
// response capture with CRC/end-bit check and Ncr timeout.
//
// state | meaning
// IDLE  | SD_CLK parked low, CMD released, accepting START/INIT
// INIT  | INIT_CLOCKS card clocks with CMD high
// SEND  | shifting the 48-bit command out on SD_CLK falling edges
// WAIT  | CMD released, looking for the response start bit for up to NCR_MAX rising edges
// RECV  | shifting in the remaining 47 response bits on rising edges
// TRAIL | TRAIL_CLOCKS card clocks with CMD high, then back to IDLE
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV  = 8'd62,
  parameter int         NCR_MAX      = 64,
  parameter int         INIT_CLOCKS  = 80,
  parameter int         TRAIL_CLOCKS = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        SD_CLK,
  inout  wire         SD_CMD
);

  localparam logic [6:0] INIT_N   = 7'(INIT_CLOCKS);
  localparam logic [6:0] TRAIL_N  = 7'(TRAIL_CLOCKS);
  localparam logic [6:0] NCR_LAST = 7'(NCR_MAX - 1);

  sd_state_e   state_q;
  logic [31:0] arg_q;
  logic [31:0] resp_q;
  logic [7:0]  div_q;
  logic [7:0]  div_lat_q;
  logic [7:0]  div_cnt_q;
  logic        sdclk_q;
  logic        cmd_oe_q;
  logic        cmd_out_q;
  logic [6:0]  cnt_q;
  logic [39:0] sr_q;
  logic [44:0] rx_sr_q;
  logic [5:0]  idx_q;
  logic [1:0]  rtype_q;
  logic [5:0]  resp_idx_q;
  logic        timeout_q;
  logic        crc_err_q;
  logic        end_err_q;
  logic        busy_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        wr_ok;
  logic        ctrl_wr;
  logic        go_init;
  logic        go_send;
  logic        tick;
  logic        rise;
  logic        fall;
  logic        cmd_in;
  logic        tx_next;
  logic [45:0] rx_word;
  logic [31:0] status;

  logic        tx_clr, tx_en, tx_bit;
  logic        rx_clr, rx_en, rx_bit;
  logic [6:0]  tx_crc;
  logic [6:0]  rx_crc;

  // One access per rising edge of i_request; ready_q is last cycle's request.
  assign access  = i_request & ~ready_q;
  assign wr_ok   = access & i_rw & ~busy_q;
  assign ctrl_wr = wr_ok & (i_address == ADDR_CTRL);
  assign go_init = ctrl_wr & i_wdata[CTRL_BIT_INIT];
  assign go_send = ctrl_wr & ~i_wdata[CTRL_BIT_INIT] & i_wdata[CTRL_BIT_START];

  assign tick   = (state_q != ST_IDLE) && (div_cnt_q == 8'd0);
  assign rise   = tick & ~sdclk_q;
  assign fall   = tick & sdclk_q;
  assign cmd_in = SD_CMD;

  // cnt_q counts bits already placed on the line; 40..46 carry the CRC MSB first, 47 the end bit.
  assign tx_next = (cnt_q < 7'd40) ? sr_q[39] :
                   (cnt_q == 7'd47) ? 1'b1 : tx_crc[3'd6 - cnt_q[2:0]];

  assign rx_word = {rx_sr_q, cmd_in};

  assign status = {20'b0, busy_q, timeout_q, crc_err_q, end_err_q, 2'b0, resp_idx_q};

  always_comb begin
    tx_clr = 1'b0;
    tx_en  = 1'b0;
    tx_bit = 1'b0;
    if (go_send && state_q == ST_IDLE) begin
      tx_clr = 1'b1;
      tx_en  = 1'b1;
    end else if (state_q == ST_SEND && fall && cnt_q < 7'd40) begin
      tx_en  = 1'b1;
      tx_bit = sr_q[39];
    end
  end

  always_comb begin
    rx_clr = 1'b0;
    rx_en  = 1'b0;
    rx_bit = 1'b0;
    if (state_q == ST_WAIT && rise && !cmd_in) begin
      rx_clr = 1'b1;
      rx_en  = 1'b1;
    end else if (state_q == ST_RECV && rise && cnt_q < 7'd40) begin
      rx_en  = 1'b1;
      rx_bit = cmd_in;
    end
  end

  sd_crc7 u_tx_crc (
    .clock_i  (i_clock),
    .reset_i  (i_reset),
    .clear_i  (tx_clr),
    .enable_i (tx_en),
    .bit_i    (tx_bit),
    .crc_o    (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clock_i  (i_clock),
    .reset_i  (i_reset),
    .clear_i  (rx_clr),
    .enable_i (rx_en),
    .bit_i    (rx_bit),
    .crc_o    (rx_crc)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      arg_q      <= '0;
      resp_q     <= '0;
      div_q      <= DEFAULT_DIV;
      div_lat_q  <= DEFAULT_DIV;
      div_cnt_q  <= '0;
      sdclk_q    <= 1'b0;
      cmd_oe_q   <= 1'b0;
      cmd_out_q  <= 1'b1;
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_sr_q    <= '0;
      idx_q      <= '0;
      rtype_q    <= RTYPE_NONE;
      resp_idx_q <= '0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_q <= i_request;

      // Read data is captured before any state change, so STATUS shows the pre-edge busy.
      if (access && !i_rw) begin
        case (i_address)
          ADDR_CTRL: rdata_q <= status;
          ADDR_ARG:  rdata_q <= arg_q;
          ADDR_RESP: rdata_q <= resp_q;
          default:   rdata_q <= {24'b0, div_q};
        endcase
      end

      if (wr_ok && i_address == ADDR_ARG) arg_q <= i_wdata;
      if (wr_ok && i_address == ADDR_DIV) div_q <= i_wdata[7:0];

      if (state_q != ST_IDLE) begin
        if (div_cnt_q == 8'd0) begin
          div_cnt_q <= div_lat_q;
          sdclk_q   <= ~sdclk_q;
        end else begin
          div_cnt_q <= div_cnt_q - 8'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (ctrl_wr) begin
            idx_q   <= i_wdata[5:0];
            rtype_q <= i_wdata[7:6];
          end
          if (go_init || go_send) begin
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            busy_q    <= 1'b1;
            div_lat_q <= div_q;
            div_cnt_q <= div_q;
            sdclk_q   <= 1'b0;
            cmd_oe_q  <= 1'b1;
          end
          if (go_init) begin
            state_q   <= ST_INIT;
            cmd_out_q <= 1'b1;
            cnt_q     <= '0;
          end else if (go_send) begin
            state_q   <= ST_SEND;
            cmd_out_q <= 1'b0;
            sr_q      <= {1'b1, i_wdata[5:0], arg_q, 1'b0};
            cnt_q     <= 7'd1;
          end
        end

        ST_INIT: begin
          if (rise) cnt_q <= cnt_q + 7'd1;
          if (fall && cnt_q == INIT_N) begin
            state_q <= ST_TRAIL;
            cnt_q   <= '0;
          end
        end

        ST_SEND: begin
          if (fall) begin
            if (cnt_q == 7'd48) begin
              cnt_q <= '0;
              if (rtype_q == RTYPE_NONE) begin
                state_q   <= ST_TRAIL;
                cmd_out_q <= 1'b1;
              end else begin
                state_q  <= ST_WAIT;
                cmd_oe_q <= 1'b0;
              end
            end else begin
              cmd_out_q <= tx_next;
              sr_q      <= {sr_q[38:0], 1'b0};
              cnt_q     <= cnt_q + 7'd1;
            end
          end
        end

        ST_WAIT: begin
          if (rise) begin
            if (!cmd_in) begin
              state_q <= ST_RECV;
              rx_sr_q <= '0;
              cnt_q   <= 7'd1;
            end else if (cnt_q == NCR_LAST) begin
              state_q   <= ST_TRAIL;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
        end

        ST_RECV: begin
          if (rise) begin
            rx_sr_q <= rx_word[44:0];
            cnt_q   <= cnt_q + 7'd1;
            if (cnt_q == 7'd47) begin
              resp_idx_q <= rx_word[45:40];
              resp_q     <= rx_word[39:8];
              crc_err_q  <= (rtype_q != RTYPE_R48_NOCRC) && (rx_crc != rx_word[7:1]);
              end_err_q  <= ~rx_word[0];
              state_q    <= ST_TRAIL;
              cnt_q      <= '0;
            end
          end
        end

        ST_TRAIL: begin
          if (rise) cnt_q <= cnt_q + 7'd1;
          // Coming from WAIT/RECV the card may still own CMD until this falling edge.
          if (fall) begin
            cmd_oe_q  <= 1'b1;
            cmd_out_q <= 1'b1;
            if (cnt_q == TRAIL_N) begin
              state_q  <= ST_IDLE;
              cmd_oe_q <= 1'b0;
              sdclk_q  <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rdata = rdata_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign SD_CLK  = sdclk_q;
  assign SD_CMD  = cmd_oe_q ? cmd_out_q : 1'bz;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with a behavioural SD card on a pulled-up CMD line.
`timescale 1ns/1ps
module tb_sd_cmd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        sd_clk;
  wire         sd_cmd;

  logic        card_oe = 1'b0;
  logic        card_bit = 1'b1;

  pullup (sd_cmd);
  assign sd_cmd = card_oe ? card_bit : 1'bz;

  always #5 clk = ~clk;

  sd_cmd_engine dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_request (req),
    .i_rw      (rw),
    .i_address (addr),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_ready   (ready),
    .o_busy    (busy),
    .SD_CLK    (sd_clk),
    .SD_CMD    (sd_cmd)
  );

  int checks = 0;
  int errors = 0;

  int          rise_cnt = 0;
  int          ones_cnt = 0;
  logic [47:0] tx_cap = '0;
  time         last_rise = 0;
  time         rise_period = 0;

  logic        card_armed = 1'b0;
  logic [47:0] card_frame = '0;
  int          card_delay = 5;
  int          fall_n = 0;
  int          bit_i = 0;

  always @(posedge sd_clk) begin
    if (rise_cnt < 48) tx_cap = {tx_cap[46:0], sd_cmd};
    if (sd_cmd === 1'b1) ones_cnt++;
    rise_period = $time - last_rise;
    last_rise = $time;
    rise_cnt++;
  end

  // Card drives its reply on falling edges, card_delay falls after the command end bit.
  always @(negedge sd_clk) begin
    if (card_armed && rise_cnt >= 48) begin
      fall_n++;
      if (fall_n == card_delay) begin
        card_oe  = 1'b1;
        card_bit = card_frame[47];
        bit_i    = 1;
      end else if (bit_i > 0 && bit_i < 48) begin
        card_bit = card_frame[47 - bit_i];
        bit_i++;
      end else if (bit_i == 48) begin
        card_oe    = 1'b0;
        card_armed = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    req = 1'b0;
  endtask

  task automatic arm_card(input logic [47:0] frame);
    card_frame = frame;
    card_delay = 5;
    fall_n     = 0;
    bit_i      = 0;
    card_armed = 1'b1;
  endtask

  task automatic start_cmd(input logic [31:0] ctrl);
    rise_cnt = 0;
    ones_cnt = 0;
    tx_cap   = '0;
    bus_write(2'd0, ctrl);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_drop"}, {47'b0, busy}, 48'd0);
  endtask

  logic [31:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst rdata", {16'b0, rdata}, 48'd0);
    chk("rst ready", {47'b0, ready}, 48'd0);
    chk("rst busy", {47'b0, busy}, 48'd0);
    chk("rst sd_clk", {47'b0, sd_clk}, 48'd0);
    chk("rst cmd_released", {47'b0, sd_cmd}, 48'd1);
    bus_read(2'd0, rd); chk("rst status", {16'b0, rd}, 48'h0);
    bus_read(2'd3, rd); chk("rst div", {16'b0, rd}, 48'h3E);
    bus_read(2'd2, rd); chk("rst resp", {16'b0, rd}, 48'h0);

    // Held request: ready tracks request, only one access
    @(negedge clk); req = 1'b1; rw = 1'b0; addr = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held ready", {47'b0, ready}, 48'd1);
    end
    chk("held rdata", {16'b0, rdata}, 48'h3E);
    req = 1'b0;
    @(negedge clk);
    chk("held ready_low", {47'b0, ready}, 48'd0);

    // CMD0, no response, default divider
    bus_write(2'd1, 32'h0);
    start_cmd(32'h0000_0100);
    chk("cmd0 busy", {47'b0, busy}, 48'd1);
    wait_idle("cmd0");
    chk("cmd0 tx", tx_cap, 48'h40_0000_0000_95);
    chk("cmd0 rises", 48'(rise_cnt), 48'd56);
    chk("cmd0 ones", 48'(ones_cnt), 48'd13);
    chk("cmd0 sd_clk_idle", {47'b0, sd_clk}, 48'd0);
    bus_read(2'd0, rd); chk("cmd0 status", {16'b0, rd}, 48'h0);

    // CMD8 with good R7 reply
    bus_write(2'd3, 32'd2);
    bus_read(2'd3, rd); chk("div rw", {16'b0, rd}, 48'd2);
    bus_write(2'd1, 32'h0000_01AA);
    arm_card(48'h08_0000_01AA_13);
    start_cmd(32'h0000_0148);
    wait_idle("cmd8");
    chk("cmd8 tx", tx_cap, 48'h48_0000_01AA_87);
    chk("cmd8 rises", 48'(rise_cnt), 48'd108);
    bus_read(2'd0, rd); chk("cmd8 status", {16'b0, rd}, 48'h008);
    bus_read(2'd2, rd); chk("cmd8 resp", {16'b0, rd}, 48'h0000_01AA);

    // Corrupted CRC, checked
    arm_card(48'h08_0000_01AA_11);
    start_cmd(32'h0000_0148);
    wait_idle("crcbad");
    bus_read(2'd0, rd); chk("crcbad status", {16'b0, rd}, 48'h208);

    // Corrupted CRC, rtype without CRC check
    arm_card(48'h08_0000_01AA_11);
    start_cmd(32'h0000_0188);
    wait_idle("nocrc");
    bus_read(2'd0, rd); chk("nocrc status", {16'b0, rd}, 48'h008);

    // End bit zero
    arm_card(48'h08_0000_01AA_12);
    start_cmd(32'h0000_0148);
    wait_idle("endbad");
    bus_read(2'd0, rd); chk("endbad status", {16'b0, rd}, 48'h108);

    // CMD17 with no reply: timeout after 64 rising edges then 8 trail clocks
    bus_write(2'd1, 32'h0);
    start_cmd(32'h0000_0151);
    wait_idle("cmd17");
    chk("cmd17 tx", tx_cap, 48'h51_0000_0000_55);
    chk("cmd17 rises", 48'(rise_cnt), 48'd120);
    bus_read(2'd0, rd); chk("cmd17 status", {16'b0, rd}, 48'h408);

    // INIT at DIV=0, writes while busy ignored
    bus_write(2'd3, 32'd0);
    start_cmd(32'h0000_0200);
    chk("init busy", {47'b0, busy}, 48'd1);
    bus_write(2'd1, 32'hDEAD_BEEF);
    bus_read(2'd0, rd); chk("init status_busy", {16'b0, rd}, 48'h808);
    wait_idle("init");
    chk("init rises", 48'(rise_cnt), 48'd88);
    chk("init ones", 48'(ones_cnt), 48'd88);
    chk("init period", 48'(rise_period), 48'd20);
    bus_read(2'd1, rd); chk("init arg_kept", {16'b0, rd}, 48'h0);
    bus_read(2'd0, rd); chk("init status", {16'b0, rd}, 48'h008);

    // Reset in the middle of SEND
    bus_write(2'd3, 32'd2);
    start_cmd(32'h0000_0100);
    for (int n = 0; n < 200 && rise_cnt < 1; n++) @(negedge clk);
    chk("mid rise_seen", {47'b0, sd_clk}, 48'd1);
    chk("mid cmd_driven", {47'b0, sd_cmd}, 48'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid cmd_released", {47'b0, sd_cmd}, 48'd1);
    chk("mid sd_clk", {47'b0, sd_clk}, 48'd0);
    chk("mid busy", {47'b0, busy}, 48'd0);
    @(negedge clk); rst = 1'b0;
    bus_read(2'd0, rd); chk("post status", {16'b0, rd}, 48'h0);
    bus_read(2'd2, rd); chk("post resp", {16'b0, rd}, 48'h0);
    start_cmd(32'h0000_0100);
    wait_idle("post cmd0");
    chk("post cmd0 tx", tx_cap, 48'h40_0000_0000_95);
    chk("post cmd0 rises", 48'(rise_cnt), 48'd56);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
